// File: rtl/alu_issue_writeback.sv
// alu_issue_writeback: single-issue operand fetch / writeback stage around alu_base.
// Owns a 32x32 register file, drives the ALU for ALU_LATENCY cycles, then retires.
`default_nettype none

module alu_issue_writeback #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        enable,
  output logic [2:0]  funct3,
  output logic [31:0] register_data_1,
  output logic [31:0] register_data_2,
  input  logic [31:0] register_data_out,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        retire_illegal,
  input  logic [4:0]  debug_addr,
  output logic [31:0] debug_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic [4:0]  rd_q;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_op;
  logic        is_legal;
  logic        accept;
  logic        exec_done;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;

  assign opcode    = instruction[6:0];
  assign rd        = instruction[11:7];
  assign rs1       = instruction[19:15];
  assign rs2       = instruction[24:20];
  assign is_op     = (opcode == OPC_OP);
  assign is_legal  = is_op || (opcode == OPC_OP_IMM);
  assign imm       = {{20{instruction[31]}}, instruction[31:20]};
  assign accept    = instr_valid && instr_ready;
  assign exec_done = (state == S_EXEC) && (cnt == 2'd0);

  // x0 is hardwired to zero on every read port
  assign rs1_val    = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val    = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign debug_data = (debug_addr == 5'd0) ? 32'd0 : rf[debug_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    instr_ready  = 1'b0;
    enable       = 1'b0;
    retire_valid = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = is_legal ? S_EXEC : S_RETIRE;
        end
      end
      S_EXEC: begin
        enable = 1'b1;
        if (cnt == 2'd0) begin
          state_next = S_RETIRE;
        end
      end
      S_RETIRE: begin
        retire_valid = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= 2'd0;
      rd_q            <= 5'd0;
      funct3          <= 3'd0;
      register_data_1 <= 32'd0;
      register_data_2 <= 32'd0;
      retire_rd       <= 5'd0;
      retire_data     <= 32'd0;
      retire_illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'd0;
      end
    end else begin
      if (accept) begin
        funct3          <= instruction[14:12];
        register_data_1 <= rs1_val;
        register_data_2 <= is_op ? rs2_val : imm;
        rd_q            <= rd;
        cnt             <= 2'(ALU_LATENCY - 1);
        // Illegal words skip EXEC, so their retire fields are set right here
        if (!is_legal) begin
          retire_rd      <= rd;
          retire_data    <= 32'd0;
          retire_illegal <= 1'b1;
        end
      end else if (state == S_EXEC && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end

      if (exec_done) begin
        retire_rd      <= rd_q;
        retire_data    <= register_data_out;
        retire_illegal <= 1'b0;
        if (rd_q != 5'd0) begin
          rf[rd_q] <= register_data_out;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_writeback.sv
// Self-checking bench: two instances (ALU_LATENCY 1 and 3) with a behavioural ALU
// and an architectural register-file reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue_writeback;

  logic        clock = 1'b0;
  logic        reset_n        [2];
  logic        instr_valid    [2];
  logic        instr_ready    [2];
  logic [31:0] instruction    [2];
  logic        enable         [2];
  logic [2:0]  funct3         [2];
  logic [31:0] rd1            [2];
  logic [31:0] rd2            [2];
  logic [31:0] alu_out        [2];
  logic        retire_valid   [2];
  logic [4:0]  retire_rd      [2];
  logic [31:0] retire_data    [2];
  logic        retire_illegal [2];
  logic [4:0]  debug_addr     [2];
  logic [31:0] debug_data     [2];

  logic [31:0] ref_rf [2][32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  // Behavioural alu_base: selects purely on funct3
  function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_out[0] = alu_f(funct3[0], rd1[0], rd2[0]);
  assign alu_out[1] = alu_f(funct3[1], rd1[1], rd2[1]);

  alu_issue_writeback #(.ALU_LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset_n(reset_n[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
    .instruction(instruction[0]), .enable(enable[0]), .funct3(funct3[0]),
    .register_data_1(rd1[0]), .register_data_2(rd2[0]), .register_data_out(alu_out[0]),
    .retire_valid(retire_valid[0]), .retire_rd(retire_rd[0]), .retire_data(retire_data[0]),
    .retire_illegal(retire_illegal[0]), .debug_addr(debug_addr[0]), .debug_data(debug_data[0])
  );

  alu_issue_writeback #(.ALU_LATENCY(3)) u_dut_l3 (
    .clock(clock), .reset_n(reset_n[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
    .instruction(instruction[1]), .enable(enable[1]), .funct3(funct3[1]),
    .register_data_1(rd1[1]), .register_data_2(rd2[1]), .register_data_out(alu_out[1]),
    .retire_valid(retire_valid[1]), .retire_rd(retire_rd[1]), .retire_data(retire_data[1]),
    .retire_illegal(retire_illegal[1]), .debug_addr(debug_addr[1]), .debug_data(debug_data[1])
  );

  function automatic logic [31:0] ref_rd(input int d, input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : ref_rf[d][a];
  endfunction

  // Issue one instruction on instance d and check it cycle by cycle against the model
  task automatic run_instr(input int d, input logic [31:0] ins);
    int lat;
    int last;
    int n;
    logic legal;
    logic [31:0] ea, eb, eres;
    lat   = (d == 0) ? 1 : 3;
    legal = (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0010011);
    ea    = ref_rd(d, ins[19:15]);
    eb    = (ins[6:0] == 7'b0110011) ? ref_rd(d, ins[24:20]) : {{20{ins[31]}}, ins[31:20]};
    eres  = legal ? alu_f(ins[14:12], ea, eb) : 32'd0;
    last  = legal ? lat + 1 : 1;
    @(negedge clock);
    instr_valid[d] = 1'b1;
    instruction[d] = ins;
    n = 0;
    while (!instr_ready[d] && n < 20) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (instr_ready[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout dut%0d: instr_ready=%b required 1", d, instr_ready[d]);
    end
    @(negedge clock);
    instr_valid[d] = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clock);
      n_cmp++;
      if (enable[d] !== (legal && c <= lat)) begin
        n_bad++;
        $display("FAIL enable dut%0d ins=%h cyc=%0d: got %b required %b", d, ins, c, enable[d], legal && c <= lat);
      end
      n_cmp++;
      if (retire_valid[d] !== (c == last)) begin
        n_bad++;
        $display("FAIL retire_valid dut%0d ins=%h cyc=%0d: got %b required %b", d, ins, c, retire_valid[d], c == last);
      end
      if (legal && c <= lat) begin
        n_cmp++;
        if (rd1[d] !== ea || rd2[d] !== eb || funct3[d] !== ins[14:12]) begin
          n_bad++;
          $display("FAIL operands dut%0d ins=%h: got %h/%h/%0d required %h/%h/%0d",
                   d, ins, rd1[d], rd2[d], funct3[d], ea, eb, ins[14:12]);
        end
      end
      if (c == last) begin
        n_cmp++;
        if (retire_rd[d] !== ins[11:7] || retire_data[d] !== eres || retire_illegal[d] !== !legal) begin
          n_bad++;
          $display("FAIL retire dut%0d ins=%h: got rd=%0d data=%h ill=%b required rd=%0d data=%h ill=%b",
                   d, ins, retire_rd[d], retire_data[d], retire_illegal[d], ins[11:7], eres, !legal);
        end
      end
    end
    if (legal && ins[11:7] != 5'd0) ref_rf[d][ins[11:7]] = eres;
    @(negedge clock);
    debug_addr[d] = ins[11:7];
    #1;
    n_cmp++;
    if (retire_valid[d] !== 1'b0 || debug_data[d] !== ref_rd(d, ins[11:7])) begin
      n_bad++;
      $display("FAIL writeback dut%0d x%0d: got rv=%b data=%h required rv=0 data=%h",
               d, ins[11:7], retire_valid[d], debug_data[d], ref_rd(d, ins[11:7]));
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; instr_valid[d] = 1'b0; instruction[d] = '0; debug_addr[d] = '0;
      for (int i = 0; i < 32; i++) ref_rf[d][i] = '0;
    end
    repeat (3) @(negedge clock);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (instr_ready[d] !== 1'b1 || enable[d] !== 1'b0 || funct3[d] !== 3'd0 || rd1[d] !== 32'd0 ||
          rd2[d] !== 32'd0 || retire_valid[d] !== 1'b0 || retire_rd[d] !== 5'd0 ||
          retire_data[d] !== 32'd0 || retire_illegal[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: rdy=%b en=%b f3=%0d a=%h b=%h rv=%b rd=%0d data=%h ill=%b required 1,0,0,0,0,0,0,0,0",
                 d, instr_ready[d], enable[d], funct3[d], rd1[d], rd2[d], retire_valid[d], retire_rd[d],
                 retire_data[d], retire_illegal[d]);
      end
      for (int a = 0; a < 32; a++) begin
        debug_addr[d] = 5'(a);
        #1;
        n_cmp++;
        if (debug_data[d] !== 32'd0) begin
          n_bad++;
          $display("FAIL reset_regfile dut%0d x%0d: got %h required 0", d, a, debug_data[d]);
        end
      end
    end
  endtask

  task automatic test_addi();
    run_instr(0, 32'h00500093);  // ADDI x1,x0,5
  endtask

  task automatic test_back_to_back();
    int c;
    logic seen_retire;
    @(negedge clock);
    instr_valid[0] = 1'b1;
    instruction[0] = 32'hFFF00113;  // ADDI x2,x0,-1
    c = 0;
    seen_retire = 1'b0;
    // c counts negedges after the first accept edge; second accept edge is c-1 when enable reappears
    while (c < 12) begin
      @(negedge clock);
      c++;
      if (c == 1) begin
        n_cmp++;
        if (enable[0] !== 1'b1 || rd2[0] !== 32'hFFFFFFFF) begin
          n_bad++;
          $display("FAIL b2b_first_operand: got en=%b b=%h required en=1 b=ffffffff", enable[0], rd2[0]);
        end
      end
      if (retire_valid[0]) begin
        seen_retire = 1'b1;
        instruction[0] = 32'h002081B3;  // ADD x3,x1,x2
      end else if (seen_retire && enable[0]) begin
        break;
      end
    end
    instr_valid[0] = 1'b0;
    n_cmp++;
    if (c != 4) begin
      n_bad++;
      $display("FAIL b2b_spacing: second accept %0d cycles after first, required 3", c - 1);
    end
    n_cmp++;
    if (rd1[0] !== 32'd5 || rd2[0] !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL b2b_add_operands: got %h/%h required 00000005/ffffffff", rd1[0], rd2[0]);
    end
    @(negedge clock);
    n_cmp++;
    if (retire_valid[0] !== 1'b1 || retire_rd[0] !== 5'd3 || retire_data[0] !== 32'd4) begin
      n_bad++;
      $display("FAIL b2b_add_retire: got rv=%b rd=%0d data=%h required 1/3/4", retire_valid[0], retire_rd[0], retire_data[0]);
    end
    ref_rf[0][2] = 32'hFFFFFFFF;
    ref_rf[0][3] = 32'd4;
    @(negedge clock);
    debug_addr[0] = 5'd3;
    #1;
    n_cmp++;
    if (debug_data[0] !== 32'd4) begin
      n_bad++;
      $display("FAIL b2b_x3: got %h required 4", debug_data[0]);
    end
  endtask

  task automatic test_x0_and_illegal();
    run_instr(0, 32'h00700013);  // ADDI x0,x0,7
    run_instr(0, 32'h0000007F);
    for (int a = 1; a < 4; a++) begin
      debug_addr[0] = 5'(a);
      #1;
      n_cmp++;
      if (debug_data[0] !== ref_rf[0][a]) begin
        n_bad++;
        $display("FAIL illegal_no_write x%0d: got %h required %h", a, debug_data[0], ref_rf[0][a]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int kind;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) begin
        ins  = $urandom;
        kind = $urandom_range(0, 9);
        if (kind < 4)      ins[6:0] = 7'b0110011;
        else if (kind < 8) ins[6:0] = 7'b0010011;
        else if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) ins[6:0] = 7'h7F;
        run_instr(d, ins);
      end
    end
  endtask

  task automatic test_latency3_reset();
    run_instr(1, 32'h00500093);
    @(negedge clock);
    instr_valid[1] = 1'b1;
    instruction[1] = 32'h00500093;
    @(negedge clock);
    instr_valid[1] = 1'b0;
    @(negedge clock);  // second EXEC cycle
    reset_n[1] = 1'b0;
    #1;
    n_cmp++;
    if (enable[1] !== 1'b0 || instr_ready[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got en=%b rdy=%b required 0/1", enable[1], instr_ready[1]);
    end
    @(negedge clock);
    reset_n[1] = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[1][i] = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++;
      if (retire_valid[1] !== 1'b0 || instr_ready[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_discard cyc=%0d: got rv=%b rdy=%b required 0/1", c, retire_valid[1], instr_ready[1]);
      end
    end
    debug_addr[1] = 5'd1;
    #1;
    n_cmp++;
    if (debug_data[1] !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_x1: got %h required 0", debug_data[1]);
    end
    run_instr(1, 32'h00500093);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_x0_and_illegal();
    test_random();
    test_latency3_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
